instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter T_WIDTH, default 3: width of the internal T-state counter; legal values 2..4.
REQ-002 Parameter DECIMAL_EN, default 1: when 1, SED/CLD are decoded; when 0, they are treated as illegal opcodes.
REQ-003 clk_ph2  in  1  phase-2 clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 rdy  in  1  ready; low stalls the sequencer.
REQ-006 IR  in  8  current opcode from the instruction register.
REQ-007 T  out  T_WIDTH  current T-state (0 = opcode fetch).
REQ-008 SYNC  out  1  high during opcode-fetch cycles.
REQ-009 ILLEGAL  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-010 DL_DB, AC_SB, ADD_SB, SB_AC, SB_DB, DL_ADL, DL_ADH, ADD_ADL, ZERO_ADH  out  1 each  bus-routing controls.
REQ-011 PCL_ADL, PCH_ADH, ADL_ABL, ADH_ABH  out  1 each  address-output controls.
REQ-012 PCL_PCL, PCH_PCH, I_PC  out  1 each  program-counter hold/increment.
REQ-013 SB_ADD, DB_ADD, nDB_ADD, SUMS  out  1 each  ALU input and operation controls.
REQ-014 AVR_V, ACR_C, DBZ_Z, DB7_N, IR5_C, IR5_D  out  1 each  status-flag load controls.

Function
REQ-015 All control outputs are registered and describe the following cycle; any signal not explicitly asserted in a cycle is 0.
REQ-016 Supported opcodes:
- ADC: 69 imm, 65 zp, 6D abs.
- SBC: E9 imm, E5 zp, ED abs.
- LDA: A9 imm, A5 zp, AD abs.
- SEC 38, CLC 18, NOP EA.
- SED F8, CLD D8 when DECIMAL_EN=1.
REQ-017 Every fetch cycle (T=0) drives PC onto the address bus (PCL_ADL, PCH_ADH, ADL_ABL, ADH_ABH), asserts PCL_PCL, PCH_PCH and I_PC, and drives SYNC=1.
REQ-018 Instruction lengths:
- imm: 2 cycles (T0, T1).
- zp: 3 cycles (T0..T2).
- abs: 4 cycles (T0..T3).
- implied: 2 cycles (T0, T1).
REQ-019 Operand fetch cycles (T1 for all modes; T2 for abs) output PC and increment it.
REQ-020 Implied instructions at T1 output PC with I_PC=0; the byte is discarded.
REQ-021 zp, final cycle: DL_ADL, ADL_ABL, ZERO_ADH, ADH_ABH, placing address 00:DL on the address bus.
REQ-022 abs, T2: also DL_DB, DB_ADD, SUMS with SB forced to zero so ADD holds ADL.
REQ-023 abs, T3: ADD_ADL, ADL_ABL, DL_ADH, ADH_ABH.
REQ-024 Final cycle of ADC: DL_DB, DB_ADD, AC_SB, SB_ADD, SUMS.
REQ-025 Final cycle of SBC: the same as ADC, but with nDB_ADD in place of DB_ADD.
REQ-026 Writeback occurs in the next T0, overlapped with the fetch of the next opcode:
- After ADC/SBC: ADD_SB, SB_AC, SB_DB, AVR_V, ACR_C, DBZ_Z, DB7_N.
- After LDA: DL_DB, SB_DB, SB_AC, DBZ_Z, DB7_N.
REQ-027 Pending writeback is held in an internal register that is set at the final cycle and cleared once consumed.
REQ-028 SEC/CLC at T1: IR5_C.
REQ-029 SED/CLD at T1: IR5_D.
REQ-030 Unsupported opcode: executes as a 2-cycle NOP (implied timing) and pulses ILLEGAL for exactly one cycle, coincident with its T1.
REQ-031 T returns to 0 after each instruction's last cycle.
REQ-032 If T reaches 2^T_WIDTH-1 without completing, the sequencer forces T=0, issues a fetch and pulses ILLEGAL.
REQ-033 rdy=0 at a rising edge freezes T, the pending-writeback state and all routing outputs.
REQ-034 While stalled, I_PC, SB_AC and all flag-load outputs are forced to 0, so no increment or register write is repeated.
REQ-035 The sequencer resumes on the first edge with rdy=1 and emits exactly the outputs it would have emitted without the stall.
REQ-036 While stalled, an ILLEGAL pulse already in progress is not extended.
REQ-037 IR is sampled only at T0->T1 decode; changes to IR at other times have no effect.

Reset
REQ-038 With rst low, all outputs are 0, T=0 and pending writeback is cleared immediately, independent of clk_ph2.
REQ-039 The first edge after rst rises performs a fetch (REQ-017) with no writeback, even if reset occurred mid-instruction.

Verification
REQ-040 Imm: IR=69 with rdy=1 -> T sequence 0,1,0; the T1 cycle has DB_ADD=SUMS=1; the next T0 has SB_AC=ACR_C=1 and I_PC=1 in both cycles.
REQ-041 Zp/abs:
- IR=A5 -> 3 cycles, ZERO_ADH=1 at T2.
- IR=ED -> 4 cycles, nDB_ADD=1 at T3, ADD_ADL=DL_ADH=1 at T3.
REQ-042 Implied: IR=38 -> T1 has IR5_C=1 and I_PC=0.
REQ-043 Decimal: IR=F8 with DECIMAL_EN=0 -> ILLEGAL=1 for one cycle and IR5_D=0.
REQ-044 Stall: IR=6D, hold rdy=0 for 3 edges during T2 -> T stays 2, I_PC=0 throughout the stall; after release the instruction completes in 2 more cycles with a single writeback.
REQ-045 Reset during T2 of IR=AD -> outputs 0 asynchronously; after release T=0, fetch asserted, SB_AC=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// T-state sequencer for a small 6502-style subset: ADC/SBC/LDA (imm, zp, abs),
// SEC/CLC, SED/CLD and NOP. All datapath controls are registered for the next cycle.
module instr_sequencer #(
  parameter int T_WIDTH    = 3,
  parameter int DECIMAL_EN = 1
) (
  input  logic               clk_ph2,
  input  logic               rst,
  input  logic               rdy,
  input  logic [7:0]         IR,
  output logic [T_WIDTH-1:0] T,
  output logic               SYNC,
  output logic               ILLEGAL,
  output logic               DL_DB,
  output logic               AC_SB,
  output logic               ADD_SB,
  output logic               SB_AC,
  output logic               SB_DB,
  output logic               DL_ADL,
  output logic               DL_ADH,
  output logic               ADD_ADL,
  output logic               ZERO_ADH,
  output logic               PCL_ADL,
  output logic               PCH_ADH,
  output logic               ADL_ABL,
  output logic               ADH_ABH,
  output logic               PCL_PCL,
  output logic               PCH_PCH,
  output logic               I_PC,
  output logic               SB_ADD,
  output logic               DB_ADD,
  output logic               nDB_ADD,
  output logic               SUMS,
  output logic               AVR_V,
  output logic               ACR_C,
  output logic               DBZ_Z,
  output logic               DB7_N,
  output logic               IR5_C,
  output logic               IR5_D
);

  // state     | meaning
  // ST_RESET  | reset released, no fetch issued yet (outputs idle)
  // ST_FETCH  | current cycle is T0; IR is decoded on the next edge
  // ST_EXEC   | current cycle is T1..Tn of the latched instruction
  typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_EXEC} state_t;
  typedef enum logic [1:0] {M_IMP, M_IMM, M_ZP, M_ABS} mode_t;
  typedef enum logic [2:0] {K_NOP, K_ADC, K_SBC, K_LDA, K_FLAGC, K_FLAGD, K_ILL} kind_t;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LDA} wb_t;

  typedef struct packed {
    logic sync, illegal;
    logic dl_db, ac_sb, add_sb, sb_ac, sb_db, dl_adl, dl_adh, add_adl, zero_adh;
    logic pcl_adl, pch_adh, adl_abl, adh_abh;
    logic pcl_pcl, pch_pch, i_pc;
    logic sb_add, db_add, ndb_add, sums;
    logic avr_v, acr_c, dbz_z, db7_n, ir5_c, ir5_d;
  } ctl_t;

  localparam logic [T_WIDTH-1:0] T_MAX = '1;

  state_t state_q, state_d;
  mode_t  mode_q, mode_d, mode_n, dec_mode;
  kind_t  kind_q, kind_d, kind_n, dec_kind;
  wb_t    wb_q, wb_d;
  ctl_t   ctl_q, ctl_d;
  logic [T_WIDTH-1:0] t_q, t_d, t_n;
  logic do_fetch, timeout;

  function automatic logic [T_WIDTH-1:0] last_t(input mode_t m);
    case (m)
      M_ZP:    return T_WIDTH'(2);
      M_ABS:   return T_WIDTH'(3);
      default: return T_WIDTH'(1);
    endcase
  endfunction

  always_comb begin
    dec_kind = K_ILL;
    dec_mode = M_IMP;
    case (IR)
      8'h69, 8'h65, 8'h6D: dec_kind = K_ADC;
      8'hE9, 8'hE5, 8'hED: dec_kind = K_SBC;
      8'hA9, 8'hA5, 8'hAD: dec_kind = K_LDA;
      8'h38, 8'h18:        dec_kind = K_FLAGC;
      8'hF8, 8'hD8:        dec_kind = (DECIMAL_EN != 0) ? K_FLAGD : K_ILL;
      8'hEA:               dec_kind = K_NOP;
      default:             dec_kind = K_ILL;
    endcase
    if (dec_kind == K_ADC || dec_kind == K_SBC || dec_kind == K_LDA) begin
      case (IR[3:0])
        4'h5:    dec_mode = M_ZP;
        4'hD:    dec_mode = M_ABS;
        default: dec_mode = M_IMM;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    mode_d   = mode_q;
    kind_d   = kind_q;
    wb_d     = wb_q;
    ctl_d    = '0;
    do_fetch = 1'b0;
    timeout  = 1'b0;
    t_n      = t_q;
    mode_n   = mode_q;
    kind_n   = kind_q;
    if (!rdy) begin
      // Hold routing, but never repeat a PC increment, register write or ILLEGAL pulse.
      ctl_d         = ctl_q;
      ctl_d.i_pc    = 1'b0;
      ctl_d.sb_ac   = 1'b0;
      ctl_d.avr_v   = 1'b0;
      ctl_d.acr_c   = 1'b0;
      ctl_d.dbz_z   = 1'b0;
      ctl_d.db7_n   = 1'b0;
      ctl_d.ir5_c   = 1'b0;
      ctl_d.ir5_d   = 1'b0;
      ctl_d.illegal = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: do_fetch = 1'b1;
        ST_FETCH: begin
          t_n    = T_WIDTH'(1);
          mode_n = dec_mode;
          kind_n = dec_kind;
        end
        default: begin
          if (t_q == last_t(mode_q)) begin
            do_fetch = 1'b1;
          end else if (t_q == T_MAX) begin
            do_fetch = 1'b1;
            timeout  = 1'b1;
          end else begin
            t_n = t_q + T_WIDTH'(1);
          end
        end
      endcase

      if (do_fetch) begin
        state_d       = ST_FETCH;
        t_d           = '0;
        wb_d          = WB_NONE;
        ctl_d.sync    = 1'b1;
        ctl_d.pcl_adl = 1'b1;
        ctl_d.pch_adh = 1'b1;
        ctl_d.adl_abl = 1'b1;
        ctl_d.adh_abh = 1'b1;
        ctl_d.pcl_pcl = 1'b1;
        ctl_d.pch_pch = 1'b1;
        ctl_d.i_pc    = 1'b1;
        ctl_d.illegal = timeout;
        case (wb_q)
          WB_ALU: begin
            ctl_d.add_sb = 1'b1;
            ctl_d.sb_ac  = 1'b1;
            ctl_d.sb_db  = 1'b1;
            ctl_d.avr_v  = 1'b1;
            ctl_d.acr_c  = 1'b1;
            ctl_d.dbz_z  = 1'b1;
            ctl_d.db7_n  = 1'b1;
          end
          WB_LDA: begin
            ctl_d.dl_db = 1'b1;
            ctl_d.sb_db = 1'b1;
            ctl_d.sb_ac = 1'b1;
            ctl_d.dbz_z = 1'b1;
            ctl_d.db7_n = 1'b1;
          end
          default: ;
        endcase
      end else begin
        state_d = ST_EXEC;
        t_d     = t_n;
        mode_d  = mode_n;
        kind_d  = kind_n;
        if (t_n == T_WIDTH'(1)) begin
          ctl_d.pcl_adl = 1'b1;
          ctl_d.pch_adh = 1'b1;
          ctl_d.adl_abl = 1'b1;
          ctl_d.adh_abh = 1'b1;
          ctl_d.pcl_pcl = 1'b1;
          ctl_d.pch_pch = 1'b1;
          ctl_d.i_pc    = (mode_n != M_IMP);
          ctl_d.ir5_c   = (kind_n == K_FLAGC);
          ctl_d.ir5_d   = (kind_n == K_FLAGD);
          ctl_d.illegal = (kind_n == K_ILL);
        end else if (t_n == T_WIDTH'(2) && mode_n == M_ABS) begin
          // High operand byte fetch; low byte parks in ADD with SB undriven (zero).
          ctl_d.pcl_adl = 1'b1;
          ctl_d.pch_adh = 1'b1;
          ctl_d.adl_abl = 1'b1;
          ctl_d.adh_abh = 1'b1;
          ctl_d.pcl_pcl = 1'b1;
          ctl_d.pch_pch = 1'b1;
          ctl_d.i_pc    = 1'b1;
          ctl_d.dl_db   = 1'b1;
          ctl_d.db_add  = 1'b1;
          ctl_d.sums    = 1'b1;
        end else if (t_n == T_WIDTH'(2)) begin
          ctl_d.dl_adl   = 1'b1;
          ctl_d.adl_abl  = 1'b1;
          ctl_d.zero_adh = 1'b1;
          ctl_d.adh_abh  = 1'b1;
        end else if (t_n == T_WIDTH'(3)) begin
          ctl_d.add_adl = 1'b1;
          ctl_d.adl_abl = 1'b1;
          ctl_d.dl_adh  = 1'b1;
          ctl_d.adh_abh = 1'b1;
        end
        if (t_n == last_t(mode_n)) begin
          if (kind_n == K_ADC || kind_n == K_SBC) begin
            ctl_d.dl_db   = 1'b1;
            ctl_d.ac_sb   = 1'b1;
            ctl_d.sb_add  = 1'b1;
            ctl_d.sums    = 1'b1;
            ctl_d.db_add  = (kind_n == K_ADC);
            ctl_d.ndb_add = (kind_n == K_SBC);
            wb_d          = WB_ALU;
          end else if (kind_n == K_LDA) begin
            wb_d = WB_LDA;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
      t_q     <= '0;
      mode_q  <= M_IMP;
      kind_q  <= K_NOP;
      wb_q    <= WB_NONE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      kind_q  <= kind_d;
      wb_q    <= wb_d;
      ctl_q   <= ctl_d;
    end
  end

  assign T        = t_q;
  assign SYNC     = ctl_q.sync;
  assign ILLEGAL  = ctl_q.illegal;
  assign DL_DB    = ctl_q.dl_db;
  assign AC_SB    = ctl_q.ac_sb;
  assign ADD_SB   = ctl_q.add_sb;
  assign SB_AC    = ctl_q.sb_ac;
  assign SB_DB    = ctl_q.sb_db;
  assign DL_ADL   = ctl_q.dl_adl;
  assign DL_ADH   = ctl_q.dl_adh;
  assign ADD_ADL  = ctl_q.add_adl;
  assign ZERO_ADH = ctl_q.zero_adh;
  assign PCL_ADL  = ctl_q.pcl_adl;
  assign PCH_ADH  = ctl_q.pch_adh;
  assign ADL_ABL  = ctl_q.adl_abl;
  assign ADH_ABH  = ctl_q.adh_abh;
  assign PCL_PCL  = ctl_q.pcl_pcl;
  assign PCH_PCH  = ctl_q.pch_pch;
  assign I_PC     = ctl_q.i_pc;
  assign SB_ADD   = ctl_q.sb_add;
  assign DB_ADD   = ctl_q.db_add;
  assign nDB_ADD  = ctl_q.ndb_add;
  assign SUMS     = ctl_q.sums;
  assign AVR_V    = ctl_q.avr_v;
  assign ACR_C    = ctl_q.acr_c;
  assign DBZ_Z    = ctl_q.dbz_z;
  assign DB7_N    = ctl_q.db7_n;
  assign IR5_C    = ctl_q.ir5_c;
  assign IR5_D    = ctl_q.ir5_d;

endmodule
